// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the core
// load/store unit (port 0) and the DMA/debug loader (port 1). One access is
// granted per cycle. Memory read data is registered into a one-cycle response
// pulse on the port that won. Out-of-range word indices are accepted but
// flagged and never reach the memory.
module dmem_arbiter #(
  parameter int DMEM_SIZE = 32768,
  parameter int RR_MODE   = 0,
  parameter int MAX_WAIT  = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0_VALID,
  output logic        REQ0_READY,
  input  logic [31:0] REQ0_ADDR,
  input  logic [31:0] REQ0_WDATA,
  input  logic [3:0]  REQ0_WSTB,
  output logic        RSP0_VALID,
  output logic [31:0] RSP0_RDATA,
  output logic        RSP0_ERR,
  input  logic        REQ1_VALID,
  output logic        REQ1_READY,
  input  logic [31:0] REQ1_ADDR,
  input  logic [31:0] REQ1_WDATA,
  input  logic [3:0]  REQ1_WSTB,
  output logic        RSP1_VALID,
  output logic [31:0] RSP1_RDATA,
  output logic        RSP1_ERR,
  output logic [29:0] M_ADDR,
  output logic [31:0] M_DATAI,
  input  logic [31:0] M_DATAO,
  output logic        M_CE,
  output logic [3:0]  M_WSTB
);

  localparam logic [7:0]  MAX_WAIT_W = 8'(MAX_WAIT);
  localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_SIZE);

  logic        last_reg;
  logic [7:0]  wait_cnt_reg;
  logic [29:0] addr_hold_reg;
  logic [31:0] wdata_hold_reg;
  logic        rsp0_valid_reg, rsp1_valid_reg;
  logic [31:0] rsp0_rdata_reg, rsp1_rdata_reg;
  logic        rsp0_err_reg, rsp1_err_reg;

  logic        grant0, grant1, grant_any;
  logic [29:0] win_word;
  logic [31:0] win_wdata;
  logic [3:0]  win_wstb;
  logic        in_range;
  logic        unused_addr_lsbs;

  // Byte offset within the word plays no part in a word-wide access.
  assign unused_addr_lsbs = ^{REQ0_ADDR[1:0], REQ1_ADDR[1:0]};

  // Grant decision: single requester always wins; on contention either
  // alternate (round-robin) or favour port 0 until port 1 has waited too long.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!RST) begin
      if (REQ0_VALID && REQ1_VALID) begin
        if (RR_MODE != 0) begin
          grant0 = last_reg;
          grant1 = !last_reg;
        end else if (wait_cnt_reg >= MAX_WAIT_W) begin
          grant1 = 1'b1;
        end else begin
          grant0 = 1'b1;
        end
      end else begin
        grant0 = REQ0_VALID;
        grant1 = REQ1_VALID;
      end
    end
  end

  assign grant_any = grant0 | grant1;
  assign win_word  = grant1 ? REQ1_ADDR[31:2] : REQ0_ADDR[31:2];
  assign win_wdata = grant1 ? REQ1_WDATA : REQ0_WDATA;
  assign win_wstb  = grant1 ? REQ1_WSTB : REQ0_WSTB;
  assign in_range  = {2'b00, win_word} < DMEM_LIMIT;

  assign REQ0_READY = grant0;
  assign REQ1_READY = grant1;

  // Memory side: address/data fall back to the held copy when idle so the
  // bus does not follow requester inputs that have not been granted.
  assign M_CE    = grant_any & in_range;
  assign M_WSTB  = M_CE ? win_wstb : 4'b0000;
  assign M_ADDR  = grant_any ? win_word : addr_hold_reg;
  assign M_DATAI = grant_any ? win_wdata : wdata_hold_reg;

  // A response registered just before reset must not be seen during reset.
  assign RSP0_VALID = rsp0_valid_reg & ~RST;
  assign RSP1_VALID = rsp1_valid_reg & ~RST;
  assign RSP0_RDATA = rsp0_rdata_reg;
  assign RSP1_RDATA = rsp1_rdata_reg;
  assign RSP0_ERR   = rsp0_err_reg;
  assign RSP1_ERR   = rsp1_err_reg;

  // Arbitration history: last winner and port 1 starvation counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_reg     <= 1'b1;
      wait_cnt_reg <= 8'd0;
    end else begin
      if (grant_any) begin
        last_reg <= grant1;
      end
      if (REQ1_VALID && !grant1) begin
        wait_cnt_reg <= (wait_cnt_reg == 8'hFF) ? 8'hFF : wait_cnt_reg + 8'd1;
      end else begin
        wait_cnt_reg <= 8'd0;
      end
    end
  end

  // Remember the last driven memory address and write data for idle cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_hold_reg  <= '0;
      wdata_hold_reg <= '0;
    end else if (grant_any) begin
      addr_hold_reg  <= win_word;
      wdata_hold_reg <= win_wdata;
    end
  end

  // Response registers: pulse on the winner, data/err held until next response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp0_valid_reg <= 1'b0;
      rsp1_valid_reg <= 1'b0;
      rsp0_rdata_reg <= '0;
      rsp1_rdata_reg <= '0;
      rsp0_err_reg   <= 1'b0;
      rsp1_err_reg   <= 1'b0;
    end else begin
      rsp0_valid_reg <= grant0;
      rsp1_valid_reg <= grant1;
      if (grant0) begin
        rsp0_rdata_reg <= in_range ? M_DATAO : 32'd0;
        rsp0_err_reg   <= !in_range;
      end
      if (grant1) begin
        rsp1_rdata_reg <= in_range ? M_DATAO : 32'd0;
        rsp1_err_reg   <= !in_range;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance and a fixed-priority
// instance (MAX_WAIT=3) share the same request stimulus, each with its own
// memory. A reference model predicts grants and responses; responses are
// queued per instance and compared one cycle later.
module tb_dmem_arbiter;

  localparam int DEPTH = 32768;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        do_init;
  logic        v0, v1;
  logic [31:0] a0, a1, d0, d1;
  logic [3:0]  s0, s1;

  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        rv0  [2];
  logic        rv1  [2];
  logic        re0  [2];
  logic        re1  [2];
  logic        mce  [2];
  logic [31:0] rd0  [2];
  logic [31:0] rd1  [2];
  logic [31:0] mdi  [2];
  logic [31:0] mdo  [2];
  logic [29:0] ma   [2];
  logic [3:0]  mws  [2];

  logic [31:0] mem     [2][DEPTH];
  logic [31:0] ref_mem [2][DEPTH];

  int n_pass  = 0;
  int n_total = 0;

  dmem_arbiter #(.DMEM_SIZE(DEPTH), .RR_MODE(1), .MAX_WAIT(8)) dut_rr (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(v0), .REQ0_READY(rdy0[0]), .REQ0_ADDR(a0), .REQ0_WDATA(d0), .REQ0_WSTB(s0),
    .RSP0_VALID(rv0[0]), .RSP0_RDATA(rd0[0]), .RSP0_ERR(re0[0]),
    .REQ1_VALID(v1), .REQ1_READY(rdy1[0]), .REQ1_ADDR(a1), .REQ1_WDATA(d1), .REQ1_WSTB(s1),
    .RSP1_VALID(rv1[0]), .RSP1_RDATA(rd1[0]), .RSP1_ERR(re1[0]),
    .M_ADDR(ma[0]), .M_DATAI(mdi[0]), .M_DATAO(mdo[0]), .M_CE(mce[0]), .M_WSTB(mws[0])
  );

  dmem_arbiter #(.DMEM_SIZE(DEPTH), .RR_MODE(0), .MAX_WAIT(3)) dut_fx (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(v0), .REQ0_READY(rdy0[1]), .REQ0_ADDR(a0), .REQ0_WDATA(d0), .REQ0_WSTB(s0),
    .RSP0_VALID(rv0[1]), .RSP0_RDATA(rd0[1]), .RSP0_ERR(re0[1]),
    .REQ1_VALID(v1), .REQ1_READY(rdy1[1]), .REQ1_ADDR(a1), .REQ1_WDATA(d1), .REQ1_WSTB(s1),
    .RSP1_VALID(rv1[1]), .RSP1_RDATA(rd1[1]), .RSP1_ERR(re1[1]),
    .M_ADDR(ma[1]), .M_DATAI(mdi[1]), .M_DATAO(mdo[1]), .M_CE(mce[1]), .M_WSTB(mws[1])
  );

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Memory devices: combinational read, byte-strobed write at the clock edge.
  assign mdo[0] = mem[0][ma[0][14:0]];
  assign mdo[1] = mem[1][ma[1][14:0]];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (do_init) begin
        for (int i = 0; i < DEPTH; i++) mem[k][i] <= pat(i);
      end else if (mce[k]) begin
        for (int b = 0; b < 4; b++)
          if (mws[k][b]) mem[k][ma[k][14:0]][8*b +: 8] <= mdi[k][8*b +: 8];
      end
    end
  end

  typedef struct packed {
    logic v0, v1, e0, e1;
    logic [31:0] rd0, rd1;
  } rsp_t;

  rsp_t sb0[$];
  rsp_t sb1[$];

  int          rr_of [2] = '{1, 0};
  int          mw_of [2] = '{8, 3};
  int          m_last[2];
  int          m_wait[2];
  int          obs_g [2];
  bit          have_addr[2];
  logic [29:0] h_addr[2];
  logic [31:0] h_data[2];
  logic [31:0] h_rd0[2];
  logic [31:0] h_rd1[2];
  logic        h_e0[2];
  logic        h_e1[2];

  // One clock cycle: drive, compare queued responses, predict this cycle's grant.
  task automatic step(input logic r,
                      input logic iv0, input logic [31:0] ia0, input logic [31:0] id0, input logic [3:0] is0,
                      input logic iv1, input logic [31:0] ia1, input logic [31:0] id1, input logic [3:0] is1);
    @(negedge clk);
    rst = r; v0 = iv0; a0 = ia0; d0 = id0; s0 = is0;
    v1 = iv1; a1 = ia1; d1 = id1; s1 = is1;
    #1;
    for (int k = 0; k < 2; k++) begin
      rsp_t        e;
      rsp_t        n;
      int          g;
      bit          have_e;
      logic [31:0] wa, wd;
      logic [3:0]  ws;
      logic [29:0] idx;
      bit          inr;
      have_e = 1'b0;
      if (k == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have_e = 1'b1; end
      if (k == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have_e = 1'b1; end
      if (have_e) begin
        if (r) begin e.v0 = 1'b0; e.v1 = 1'b0; end
        n_total++;
        if ({rv0[k], rv1[k], re0[k], re1[k], rd0[k], rd1[k]} !== {e.v0, e.v1, e.e0, e.e1, e.rd0, e.rd1})
          $display("FAIL rsp inst%0d t=%0t: got v=%b%b err=%b%b rd0=%h rd1=%h, want v=%b%b err=%b%b rd0=%h rd1=%h",
                   k, $time, rv0[k], rv1[k], re0[k], re1[k], rd0[k], rd1[k],
                   e.v0, e.v1, e.e0, e.e1, e.rd0, e.rd1);
        else n_pass++;
      end

      g = -1;
      if (!r) begin
        if (iv0 && iv1) begin
          if (rr_of[k] != 0) g = (m_last[k] == 1) ? 0 : 1;
          else               g = (m_wait[k] >= mw_of[k]) ? 1 : 0;
        end else if (iv0) g = 0;
        else if (iv1) g = 1;
      end
      obs_g[k] = rdy0[k] ? 0 : (rdy1[k] ? 1 : -1);
      n_total++;
      if ({rdy0[k], rdy1[k]} !== {g == 0, g == 1})
        $display("FAIL grant inst%0d t=%0t: ready=%b%b want=%b%b", k, $time, rdy0[k], rdy1[k], g == 0, g == 1);
      else n_pass++;

      wa  = (g == 1) ? ia1 : ia0;
      wd  = (g == 1) ? id1 : id0;
      ws  = (g == 1) ? is1 : is0;
      idx = wa[31:2];
      inr = (g >= 0) && (idx < 30'(DEPTH));
      n_total++;
      if ({mce[k], mws[k]} !== {inr, inr ? ws : 4'b0000})
        $display("FAIL mem_ctl inst%0d t=%0t: ce=%b wstb=%b want ce=%b wstb=%b", k, $time, mce[k], mws[k], inr, inr ? ws : 4'b0000);
      else n_pass++;
      if (inr || (g < 0 && have_addr[k])) begin
        logic [29:0] xa;
        logic [31:0] xd;
        xa = inr ? idx : h_addr[k];
        xd = inr ? wd : h_data[k];
        n_total++;
        if ({ma[k], mdi[k]} !== {xa, xd})
          $display("FAIL mem_bus inst%0d t=%0t: addr=%h data=%h want addr=%h data=%h", k, $time, ma[k], mdi[k], xa, xd);
        else n_pass++;
      end

      if (r) begin
        h_rd0[k] = '0; h_rd1[k] = '0; h_e0[k] = 1'b0; h_e1[k] = 1'b0;
      end else if (g == 0) begin
        h_rd0[k] = inr ? ref_mem[k][idx[14:0]] : 32'd0; h_e0[k] = !inr;
      end else if (g == 1) begin
        h_rd1[k] = inr ? ref_mem[k][idx[14:0]] : 32'd0; h_e1[k] = !inr;
      end
      n.v0 = (g == 0); n.v1 = (g == 1);
      n.e0 = h_e0[k]; n.e1 = h_e1[k]; n.rd0 = h_rd0[k]; n.rd1 = h_rd1[k];
      if (k == 0) sb0.push_back(n); else sb1.push_back(n);

      if (inr)
        for (int b = 0; b < 4; b++)
          if (ws[b]) ref_mem[k][idx[14:0]][8*b +: 8] = wd[8*b +: 8];

      if (r) begin
        m_last[k] = 1; m_wait[k] = 0; have_addr[k] = 1'b0;
      end else begin
        if (g >= 0) begin
          m_last[k] = g; have_addr[k] = inr; h_addr[k] = idx; h_data[k] = wd;
        end
        if (iv1 && g != 1) m_wait[k] = (m_wait[k] >= 255) ? 255 : m_wait[k] + 1;
        else m_wait[k] = 0;
      end
    end
  endtask

  task automatic idle(input logic r);
    step(r, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic p0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    step(1'b0, 1'b1, a, d, s, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic p1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a, d, s);
  endtask

  task automatic test_reset();
    idle(1'b1);
    do_init = 1'b0;
    idle(1'b1);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({rdy0[k], rdy1[k], mce[k], mws[k]} !== 7'b0)
        $display("FAIL reset_ctl inst%0d: ready=%b%b ce=%b wstb=%b want all 0", k, rdy0[k], rdy1[k], mce[k], mws[k]);
      else n_pass++;
    end
    idle(1'b0);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({rv0[k], rv1[k], re0[k], re1[k], rd0[k], rd1[k]} !== 68'b0)
        $display("FAIL reset_rsp inst%0d: v=%b%b err=%b%b rd0=%h rd1=%h want 0", k, rv0[k], rv1[k], re0[k], re1[k], rd0[k], rd1[k]);
      else n_pass++;
    end
  endtask

  task automatic test_write_read();
    p0(32'h10, 32'hAABBCCDD, 4'b1111);
    p0(32'h10, 32'h0, 4'b0000);
    p0(32'h10, 32'h00EE0000, 4'b0100);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({rv0[k], re0[k], rd0[k]} !== {1'b1, 1'b0, 32'hAABBCCDD})
        $display("FAIL raw_read inst%0d: v=%b err=%b rd=%h want v=1 err=0 rd=aabbccdd", k, rv0[k], re0[k], rd0[k]);
      else n_pass++;
    end
    p0(32'h10, 32'h0, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (rd0[k] !== 32'hAABBCCDD)
        $display("FAIL byte_wr_old inst%0d: rd=%h want aabbccdd", k, rd0[k]);
      else n_pass++;
    end
    idle(1'b0);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({rv0[k], rd0[k]} !== {1'b1, 32'hAAEECCDD})
        $display("FAIL byte_wr_new inst%0d: v=%b rd=%h want v=1 rd=aaeeccdd", k, rv0[k], rd0[k]);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    int prev;
    idle(1'b1);
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 32'h100 + 32'(4*i), 32'h0, 4'h0, 1'b1, 32'h200 + 32'(4*i), 32'h0, 4'h0);
      n_total++;
      if (obs_g[0] !== i % 2)
        $display("FAIL rr_seq cycle%0d: grant=%0d want %0d", i, obs_g[0], i % 2);
      else n_pass++;
      if (prev >= 0) begin
        n_total++;
        if ({rv0[0], rv1[0]} !== {prev == 0, prev == 1})
          $display("FAIL rr_rsp cycle%0d: v=%b%b want %b%b", i, rv0[0], rv1[0], prev == 0, prev == 1);
        else n_pass++;
      end
      prev = i % 2;
    end
    idle(1'b0);
  endtask

  task automatic test_fixed_wait();
    int exp_seq [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    idle(1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 32'h300, 32'h0, 4'h0, 1'b1, 32'h304, 32'h0, 4'h0);
      n_total++;
      if (obs_g[1] !== exp_seq[i])
        $display("FAIL fixed_seq cycle%0d: grant=%0d want %0d", i, obs_g[1], exp_seq[i]);
      else n_pass++;
    end
    idle(1'b0);
  endtask

  task automatic test_out_of_range();
    p0(32'h0, 32'h12345678, 4'b1111);
    p1(32'h00020000, 32'h0, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({rdy1[k], mce[k]} !== 2'b10)
        $display("FAIL oor_grant inst%0d: ready1=%b ce=%b want 1 0", k, rdy1[k], mce[k]);
      else n_pass++;
    end
    p1(32'h00020000, 32'hFFFFFFFF, 4'b1111);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({rv1[k], re1[k], rd1[k]} !== {1'b1, 1'b1, 32'h0})
        $display("FAIL oor_rsp inst%0d: v=%b err=%b rd=%h want v=1 err=1 rd=0", k, rv1[k], re1[k], rd1[k]);
      else n_pass++;
    end
    p1(32'h80000000, 32'hFFFFFFFF, 4'b1111);
    p0(32'h0, 32'h0, 4'b0000);
    idle(1'b0);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({rd0[k], mem[k][0]} !== {32'h12345678, 32'h12345678})
        $display("FAIL oor_alias inst%0d: rd=%h mem0=%h want 12345678", k, rd0[k], mem[k][0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_discard();
    p0(32'h10, 32'h0, 4'b0000);
    idle(1'b1);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({rv0[k], rv1[k]} !== 2'b00)
        $display("FAIL rst_discard inst%0d: v=%b%b want 00", k, rv0[k], rv1[k]);
      else n_pass++;
    end
    step(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b1, 32'h24, 32'h0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({rv0[k], rv1[k], obs_g[k]} !== {2'b00, 32'sd0})
        $display("FAIL post_rst inst%0d: v=%b%b grant=%0d want v=00 grant=0", k, rv0[k], rv1[k], obs_g[k]);
      else n_pass++;
    end
    idle(1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra0, ra1;
      ra0 = ($urandom_range(0, 9) == 0) ? 32'h00020000 + 32'(4 * $urandom_range(0, 3))
                                        : 32'(4 * $urandom_range(0, 7));
      ra1 = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : 32'(4 * $urandom_range(0, 7));
      step(1'b0,
           1'($urandom_range(0, 3) != 0), ra0, $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 2) != 0), ra1, $urandom, 4'($urandom_range(0, 15)));
    end
    idle(1'b0);
    idle(1'b0);
  endtask

  initial begin
    do_init = 1'b1;
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0; s0 = '0; s1 = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[k][i] = pat(i);
      m_last[k] = 1; m_wait[k] = 0; have_addr[k] = 1'b0; obs_g[k] = -1;
      h_addr[k] = '0; h_data[k] = '0; h_rd0[k] = '0; h_rd1[k] = '0; h_e0[k] = 1'b0; h_e1[k] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_wait();
    test_out_of_range();
    test_reset_discard();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single-ported, word-wide data memory between the core load/store unit (port 0) and the DMA/debug loader (port 1). It accepts valid/ready requests, grants at most one access per cycle, and drives the memory address, write data, CE and byte strobes. Memory read data arrives combinationally and is registered into a one-cycle response pulse on the granted port. Out-of-range addresses are rejected with an error flag so they never alias into the array.

Parameters:
DMEM_SIZE, 32768, memory depth in 32-bit words; legal word index range 0..DMEM_SIZE-1
RR_MODE, 0, 0 = fixed priority (port 0 wins, with anti-starvation); 1 = round-robin
MAX_WAIT, 8, fixed mode only: consecutive stalled cycles on port 1 before port 1 is forced to win; range 1..255

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  synchronous, active-high reset
REQ0_VALID  in  1  port 0 request valid
REQ0_READY  out  1  port 0 request accepted this cycle
REQ0_ADDR  in  32  port 0 byte address; bits [1:0] ignored
REQ0_WDATA  in  32  port 0 write data
REQ0_WSTB  in  4  port 0 byte strobes; 0000 = read
RSP0_VALID  out  1  port 0 response pulse
RSP0_RDATA  out  32  port 0 read data: the word before any write
RSP0_ERR  out  1  port 0 address out of range
REQ1_VALID, REQ1_READY, REQ1_ADDR, REQ1_WDATA, REQ1_WSTB, RSP1_VALID, RSP1_RDATA, RSP1_ERR  as for port 0
M_ADDR  out  30  memory word address [31:2]
M_DATAI  out  32  memory write data
M_DATAO  in  32  memory read data; combinational from M_ADDR
M_CE  out  1  memory enable
M_WSTB  out  4  memory byte strobes

Behaviour:
- Reset, applied at a rising edge with RST=1: RSPx_VALID=0, RSPx_RDATA=0, RSPx_ERR=0, LAST=1, WAIT_CNT=0. During RST=1: REQx_READY=0, M_CE=0, M_WSTB=0.
- A response registered before reset is discarded. No RSP pulse appears in the cycle after reset.
- Grant is combinational within cycle N. At most one of REQ0_READY and REQ1_READY is high. READY=1 only when the port's VALID=1 and RST=0.
- Grant rules:
  - Only one port valid: that port wins.
  - Both valid, RR_MODE=1: the port other than LAST wins.
  - Both valid, RR_MODE=0: port 0 wins, unless WAIT_CNT>=MAX_WAIT, in which case port 1 wins.
- LAST <= index of the granted port on every grant.
- WAIT_CNT:
  - Increments, saturating at 255, each cycle REQ1_VALID=1 and port 1 is not granted.
  - Clears when port 1 is granted or REQ1_VALID=0.
- Range check, for the winner: word index = ADDR[31:2]; in range iff index < DMEM_SIZE.
- In-range grant:
  - M_ADDR = ADDR[31:2], M_CE=1, M_WSTB = winner's WSTB, M_DATAI = winner's WDATA.
  - The write commits at the end of cycle N.
- Out-of-range grant: the request is still accepted, with M_CE=0 and M_WSTB=0.
- No grant: M_CE=0, M_WSTB=0. M_ADDR and M_DATAI hold their last driven values, with no combinational toggling when idle.
- Response timing, cycle N+1:
  - RSPw_VALID=1 for exactly one cycle.
  - RSPw_RDATA = M_DATAO sampled at the end of cycle N, i.e. the old word for writes. It is 0 when ERR.
  - RSPw_ERR=1 iff out of range.
  - The other port's RSP_VALID=0.
  - RDATA and ERR hold their values until the next response on that port.
- Throughput: one accepted request per cycle; back-to-back grants are allowed. Responses have no backpressure; the requester must accept them.
- Requester rule: VALID, ADDR, WDATA and WSTB stay stable until READY. The arbiter does not latch unaccepted requests.
- Read-after-write to the same word on consecutive cycles: the second access sees the new data, because memory is updated at the end of the first cycle.

Test Plan:
1. Port 0 write ADDR=0x10, WDATA=0xAABBCCDD, WSTB=1111; next cycle port 0 read 0x10 -> write: READY0 in the same cycle, RSP0_VALID next cycle; read: RSP0_RDATA=0xAABBCCDD, ERR=0.
2. Byte write WSTB=0100, WDATA=0x00EE0000 to that word, then read -> RDATA=0xAAEECCDD; the write's own response RDATA=0xAABBCCDD.
3. RR_MODE=1, both ports valid continuously for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; RSP pulses alternate one cycle later.
4. RR_MODE=0, MAX_WAIT=3, both valid continuously -> grants 0,0,0,1,0,0,0,1; WAIT_CNT returns to 0 after each port-1 grant.
5. Port 1 read at byte address DMEM_SIZE*4 (0x20000) -> READY1=1, M_CE=0, next cycle RSP1_VALID=1, ERR=1, RDATA=0; memory contents unchanged, including word 0.
6. Grant in cycle N with RST=1 in cycle N+1 -> no RSP pulse; after reset, both valid with RR_MODE=1 -> port 0 granted first.
